// File: rtl/i2s_pkg.sv
// i2s_pkg: definitions shared by the I2S transmit scheduler and its
// clock edge detector (and later the serializer).
//   DEFAULT_DATA_WIDTH : sample width per channel used by sat_add and as the
//                        scheduler's default DATA_WIDTH
//   MODE_*             : encoding of the scheduler's i_mode input
//   state_t            : scheduler FSM state encoding
//   sat_add            : signed add of two samples, clamped to the sample range
package i2s_pkg;

  localparam int DEFAULT_DATA_WIDTH = 24;

  localparam logic [1:0] MODE_MUTE = 2'd0;
  localparam logic [1:0] MODE_SRC0 = 2'd1;
  localparam logic [1:0] MODE_SRC1 = 2'd2;
  localparam logic [1:0] MODE_SUM  = 2'd3;

  typedef enum logic [1:0] {
    ST_WAIT_LR_RISE = 2'd0,
    ST_COUNT        = 2'd1,
    ST_ISSUE        = 2'd2
  } state_t;

  // Sign-extend both operands by one bit so the sum cannot wrap, then clamp.
  // The two top bits of the wide sum disagree exactly when the result is out
  // of range; the very top bit tells which way it overflowed.
  function automatic logic [DEFAULT_DATA_WIDTH-1:0] sat_add(
    input logic [DEFAULT_DATA_WIDTH-1:0] a,
    input logic [DEFAULT_DATA_WIDTH-1:0] b
  );
    logic [DEFAULT_DATA_WIDTH:0] sum;
    sum = {a[DEFAULT_DATA_WIDTH-1], a} + {b[DEFAULT_DATA_WIDTH-1], b};
    if (sum[DEFAULT_DATA_WIDTH] != sum[DEFAULT_DATA_WIDTH-1]) begin
      if (sum[DEFAULT_DATA_WIDTH]) begin
        sat_add = {1'b1, {(DEFAULT_DATA_WIDTH-1){1'b0}}};
      end else begin
        sat_add = {1'b0, {(DEFAULT_DATA_WIDTH-1){1'b1}}};
      end
    end else begin
      sat_add = sum[DEFAULT_DATA_WIDTH-1:0];
    end
  endfunction

endpackage

// File: rtl/i2s_clock_edge_detect.sv
// i2s_clock_edge_detect: brings an asynchronous codec clock into the i_clock
// domain and produces registered one-cycle rise and fall pulses.
//   i_clock  : system clock
//   i_reset  : synchronous active-high reset
//   i_async  : asynchronous input clock (bit clock or LR clock)
//   o_rise   : one-cycle pulse per detected rising edge
//   o_fall   : one-cycle pulse per detected falling edge
module i2s_clock_edge_detect (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_async,
  output logic o_rise,
  output logic o_fall
);

  logic       sync1_q, sync1_d;
  logic       sync2_q, sync2_d;
  logic       dly_q, dly_d;
  logic [1:0] fill_q, fill_d;
  logic       rise_q, rise_d;
  logic       fall_q, fall_d;
  logic       armed;

  // Pulses are suppressed until the synchroniser and delay stages have been
  // refilled after reset; otherwise a clock that is high while reset is
  // released would look like a fresh rising edge.
  always_comb begin
    sync1_d = i_async;
    sync2_d = sync1_q;
    dly_d   = sync2_q;
    fill_d  = (fill_q == 2'd3) ? fill_q : fill_q + 2'd1;
    armed   = (fill_q == 2'd3);
    rise_d  = armed & sync2_q & ~dly_q;
    fall_d  = armed & ~sync2_q & dly_q;
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      dly_q   <= 1'b0;
      fill_q  <= 2'd0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      dly_q   <= dly_d;
      fill_q  <= fill_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign o_rise = rise_q;
  assign o_fall = fall_q;

endmodule

// File: rtl/i2s_tx_scheduler.sv
// i2s_tx_scheduler: picks or mixes stereo samples from two sources and hands
// exactly one pair per LR frame to the I2S serializer, late enough in the
// frame that the serializer has returned to idle.
//   i_clock, i_reset                   : system clock, synchronous active-high reset
//   i_codec_bit_clock, i_codec_lr_clock: asynchronous I2S clocks
//   i_enable                           : 0 stops issuing and flushes the buffers
//   i_mode                             : 0 mute, 1 source0, 2 source1, 3 saturating sum
//   i_srcN_left/right/valid, o_srcN_ready : per-source sample handshake
//   o_data_left/right, o_data_valid    : issue to the serializer (one-cycle pulse)
//   o_underrun, o_underrun_count       : underrun pulse and saturating count
//   o_frame_count                      : wrapping count of issued frames
module i2s_tx_scheduler #(
  parameter int DATA_WIDTH       = i2s_pkg::DEFAULT_DATA_WIDTH,
  parameter int ISSUE_BCLK_DELAY = 28,
  parameter int HOLD_ON_UNDERRUN = 1,
  parameter int CNT_WIDTH        = 16
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_codec_bit_clock,
  input  logic                  i_codec_lr_clock,
  input  logic                  i_enable,
  input  logic [1:0]            i_mode,
  input  logic [DATA_WIDTH-1:0] i_src0_left,
  input  logic [DATA_WIDTH-1:0] i_src0_right,
  input  logic                  i_src0_valid,
  output logic                  o_src0_ready,
  input  logic [DATA_WIDTH-1:0] i_src1_left,
  input  logic [DATA_WIDTH-1:0] i_src1_right,
  input  logic                  i_src1_valid,
  output logic                  o_src1_ready,
  output logic [DATA_WIDTH-1:0] o_data_left,
  output logic [DATA_WIDTH-1:0] o_data_right,
  output logic                  o_data_valid,
  output logic                  o_underrun,
  output logic [CNT_WIDTH-1:0]  o_underrun_count,
  output logic [CNT_WIDTH-1:0]  o_frame_count
);

  import i2s_pkg::*;

  localparam logic [5:0] ISSUE_AT = 6'(ISSUE_BCLK_DELAY);

  logic bclk_rise, lr_rise, bclk_fall_unused, lr_fall_unused;

  i2s_clock_edge_detect u_bclk_edge (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_async (i_codec_bit_clock),
    .o_rise  (bclk_rise),
    .o_fall  (bclk_fall_unused)
  );

  i2s_clock_edge_detect u_lr_edge (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_async (i_codec_lr_clock),
    .o_rise  (lr_rise),
    .o_fall  (lr_fall_unused)
  );

  state_t                state_q, state_d;
  logic [5:0]            bclk_cnt_q, bclk_cnt_d;
  logic [1:0]            mode_q, mode_d;
  logic                  buf0_full_q, buf0_full_d, buf1_full_q, buf1_full_d;
  logic [DATA_WIDTH-1:0] buf0_l_q, buf0_l_d, buf0_r_q, buf0_r_d;
  logic [DATA_WIDTH-1:0] buf1_l_q, buf1_l_d, buf1_r_q, buf1_r_d;
  logic [DATA_WIDTH-1:0] last0_l_q, last0_l_d, last0_r_q, last0_r_d;
  logic [DATA_WIDTH-1:0] last1_l_q, last1_l_d, last1_r_q, last1_r_d;
  logic [CNT_WIDTH-1:0]  underrun_cnt_q, underrun_cnt_d;
  logic [CNT_WIDTH-1:0]  frame_cnt_q, frame_cnt_d;

  logic                  issue, underrun, load0, load1;
  logic [DATA_WIDTH-1:0] eff0_l, eff0_r, eff1_l, eff1_r, out_l, out_r;

  // Frame sequencing: wait for LR rise, count bit-clock rises, issue once.
  // The transition to ISSUE happens on the same pulse that brings the count
  // to ISSUE_AT, so the issue pulse lands one cycle after that bit-clock rise.
  always_comb begin
    state_d    = state_q;
    bclk_cnt_d = bclk_cnt_q;
    mode_d     = mode_q;
    issue      = 1'b0;
    case (state_q)
      ST_WAIT_LR_RISE: begin
        if (lr_rise) begin
          mode_d     = i_mode;
          bclk_cnt_d = 6'd0;
          state_d    = ST_COUNT;
        end
      end
      ST_COUNT: begin
        if (bclk_rise) begin
          bclk_cnt_d = bclk_cnt_q + 6'd1;
          if (bclk_cnt_q + 6'd1 == ISSUE_AT) begin
            state_d = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        issue   = 1'b1;
        state_d = ST_WAIT_LR_RISE;
      end
      default: state_d = ST_WAIT_LR_RISE;
    endcase
    if (!i_enable) begin
      state_d = ST_WAIT_LR_RISE;
      issue   = 1'b0;
    end
  end

  // Each source's contribution: its buffered pair, or on an empty buffer
  // either its last issued pair (hold) or zeros. In sum mode this means only
  // the missing source is replaced by its history.
  always_comb begin
    eff0_l = buf0_l_q;
    eff0_r = buf0_r_q;
    eff1_l = buf1_l_q;
    eff1_r = buf1_r_q;
    if (!buf0_full_q) begin
      eff0_l = (HOLD_ON_UNDERRUN != 0) ? last0_l_q : '0;
      eff0_r = (HOLD_ON_UNDERRUN != 0) ? last0_r_q : '0;
    end
    if (!buf1_full_q) begin
      eff1_l = (HOLD_ON_UNDERRUN != 0) ? last1_l_q : '0;
      eff1_r = (HOLD_ON_UNDERRUN != 0) ? last1_r_q : '0;
    end
    out_l    = '0;
    out_r    = '0;
    underrun = 1'b0;
    case (mode_q)
      MODE_SRC0: begin
        out_l    = eff0_l;
        out_r    = eff0_r;
        underrun = ~buf0_full_q;
      end
      MODE_SRC1: begin
        out_l    = eff1_l;
        out_r    = eff1_r;
        underrun = ~buf1_full_q;
      end
      MODE_SUM: begin
        out_l    = sat_add(eff0_l, eff1_l);
        out_r    = sat_add(eff0_r, eff1_r);
        underrun = ~buf0_full_q | ~buf1_full_q;
      end
      default: begin
        out_l    = '0;
        out_r    = '0;
        underrun = 1'b0;
      end
    endcase
  end

  // Buffers, last-pair history and counters. Every issue empties both
  // buffers so an unselected source is drained rather than stalled.
  always_comb begin
    load0 = i_src0_valid & o_src0_ready;
    load1 = i_src1_valid & o_src1_ready;

    buf0_l_d    = load0 ? i_src0_left  : buf0_l_q;
    buf0_r_d    = load0 ? i_src0_right : buf0_r_q;
    buf1_l_d    = load1 ? i_src1_left  : buf1_l_q;
    buf1_r_d    = load1 ? i_src1_right : buf1_r_q;
    buf0_full_d = buf0_full_q;
    buf1_full_d = buf1_full_q;
    if (!i_enable) begin
      buf0_full_d = 1'b0;
      buf1_full_d = 1'b0;
    end else begin
      if (load0) buf0_full_d = 1'b1;
      else if (issue) buf0_full_d = 1'b0;
      if (load1) buf1_full_d = 1'b1;
      else if (issue) buf1_full_d = 1'b0;
    end

    last0_l_d = last0_l_q;
    last0_r_d = last0_r_q;
    last1_l_d = last1_l_q;
    last1_r_d = last1_r_q;
    if (issue && buf0_full_q && (mode_q == MODE_SRC0 || mode_q == MODE_SUM)) begin
      last0_l_d = buf0_l_q;
      last0_r_d = buf0_r_q;
    end
    if (issue && buf1_full_q && (mode_q == MODE_SRC1 || mode_q == MODE_SUM)) begin
      last1_l_d = buf1_l_q;
      last1_r_d = buf1_r_q;
    end

    frame_cnt_d    = issue ? frame_cnt_q + CNT_WIDTH'(1) : frame_cnt_q;
    underrun_cnt_d = underrun_cnt_q;
    if (issue && underrun && (underrun_cnt_q != '1)) begin
      underrun_cnt_d = underrun_cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q        <= ST_WAIT_LR_RISE;
      bclk_cnt_q     <= 6'd0;
      mode_q         <= MODE_MUTE;
      buf0_full_q    <= 1'b0;
      buf1_full_q    <= 1'b0;
      buf0_l_q       <= '0;
      buf0_r_q       <= '0;
      buf1_l_q       <= '0;
      buf1_r_q       <= '0;
      last0_l_q      <= '0;
      last0_r_q      <= '0;
      last1_l_q      <= '0;
      last1_r_q      <= '0;
      underrun_cnt_q <= '0;
      frame_cnt_q    <= '0;
    end else begin
      state_q        <= state_d;
      bclk_cnt_q     <= bclk_cnt_d;
      mode_q         <= mode_d;
      buf0_full_q    <= buf0_full_d;
      buf1_full_q    <= buf1_full_d;
      buf0_l_q       <= buf0_l_d;
      buf0_r_q       <= buf0_r_d;
      buf1_l_q       <= buf1_l_d;
      buf1_r_q       <= buf1_r_d;
      last0_l_q      <= last0_l_d;
      last0_r_q      <= last0_r_d;
      last1_l_q      <= last1_l_d;
      last1_r_q      <= last1_r_d;
      underrun_cnt_q <= underrun_cnt_d;
      frame_cnt_q    <= frame_cnt_d;
    end
  end

  // Ready depends only on registered state and i_enable, never on valid.
  assign o_src0_ready     = ~buf0_full_q & i_enable;
  assign o_src1_ready     = ~buf1_full_q & i_enable;
  assign o_data_valid     = issue;
  assign o_data_left      = issue ? out_l : '0;
  assign o_data_right     = issue ? out_r : '0;
  assign o_underrun       = issue & underrun;
  assign o_underrun_count = underrun_cnt_q;
  assign o_frame_count    = frame_cnt_q;

endmodule

// File: tb/tb_i2s_tx_scheduler.sv
// tb_i2s_tx_scheduler: directed bench for i2s_tx_scheduler. Two instances
// share all inputs, one holding the last pair on underrun and one issuing
// zeros. The bench drives the codec bit/LR clocks frame by frame itself.
module tb_i2s_tx_scheduler;

  localparam int DW = 24;

  logic          i_clock = 1'b0;
  logic          i_reset, bclk, lrclk, i_enable;
  logic [1:0]    i_mode;
  logic [DW-1:0] s0l, s0r, s1l, s1r;
  logic          s0v, s1v;

  logic          hReady0, hReady1, hValid, hUrun;
  logic [DW-1:0] hL, hR;
  logic [15:0]   hUcnt, hFcnt;
  logic          zReady0, zReady1, zValid, zUrun;
  logic [DW-1:0] zL, zR;
  logic [15:0]   zUcnt, zFcnt;

  i2s_tx_scheduler #(.DATA_WIDTH(DW), .ISSUE_BCLK_DELAY(28), .HOLD_ON_UNDERRUN(1), .CNT_WIDTH(16)) dut_hold (
    .i_clock(i_clock), .i_reset(i_reset), .i_codec_bit_clock(bclk), .i_codec_lr_clock(lrclk),
    .i_enable(i_enable), .i_mode(i_mode),
    .i_src0_left(s0l), .i_src0_right(s0r), .i_src0_valid(s0v), .o_src0_ready(hReady0),
    .i_src1_left(s1l), .i_src1_right(s1r), .i_src1_valid(s1v), .o_src1_ready(hReady1),
    .o_data_left(hL), .o_data_right(hR), .o_data_valid(hValid), .o_underrun(hUrun),
    .o_underrun_count(hUcnt), .o_frame_count(hFcnt)
  );

  i2s_tx_scheduler #(.DATA_WIDTH(DW), .ISSUE_BCLK_DELAY(28), .HOLD_ON_UNDERRUN(0), .CNT_WIDTH(16)) dut_zero (
    .i_clock(i_clock), .i_reset(i_reset), .i_codec_bit_clock(bclk), .i_codec_lr_clock(lrclk),
    .i_enable(i_enable), .i_mode(i_mode),
    .i_src0_left(s0l), .i_src0_right(s0r), .i_src0_valid(s0v), .o_src0_ready(zReady0),
    .i_src1_left(s1l), .i_src1_right(s1r), .i_src1_valid(s1v), .o_src1_ready(zReady1),
    .o_data_left(zL), .o_data_right(zR), .o_data_valid(zValid), .o_underrun(zUrun),
    .o_underrun_count(zUcnt), .o_frame_count(zFcnt)
  );

  always #5 i_clock = ~i_clock;

  int total = 0;
  int bad = 0;
  int bclkRises = 0;
  int validA = 0, validB = 0, urunA = 0, urunB = 0, bclkAtValid = 0;
  logic [DW-1:0] lastLA = '0, lastRA = '0, lastLB = '0, lastRB = '0;
  int vA0, vB0, uA0, uB0;

  // Observe issues on the falling edge, away from the DUT's active edge.
  always @(negedge i_clock) begin
    if (hValid) begin
      validA++;
      lastLA = hL;
      lastRA = hR;
      bclkAtValid = bclkRises;
    end
    if (hUrun) urunA++;
    if (zValid) begin
      validB++;
      lastLB = zL;
      lastRB = zR;
    end
    if (zUrun) urunB++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic offerSrc0(input logic [DW-1:0] l, input logic [DW-1:0] r);
    int waited;
    waited = 0;
    @(posedge i_clock); #1;
    s0l = l; s0r = r; s0v = 1'b1;
    while (!hReady0 && waited < 500) begin
      @(posedge i_clock); #1;
      waited++;
    end
    checkOutput("src0_accept", {31'd0, hReady0}, 32'd1);
    @(posedge i_clock); #1;
    s0v = 1'b0;
  endtask

  task automatic offerSrc1(input logic [DW-1:0] l, input logic [DW-1:0] r);
    int waited;
    waited = 0;
    @(posedge i_clock); #1;
    s1l = l; s1r = r; s1v = 1'b1;
    while (!hReady1 && waited < 500) begin
      @(posedge i_clock); #1;
      waited++;
    end
    checkOutput("src1_accept", {31'd0, hReady1}, 32'd1);
    @(posedge i_clock); #1;
    s1v = 1'b0;
  endtask

  // One full LR frame: 64 bit clocks, LR high for the first 32. Optionally
  // change i_mode or pulse reset right after a given bit-clock rise.
  task automatic applyStimulus(input int chgAt, input logic [1:0] chgMode, input int rstAt);
    vA0 = validA; vB0 = validB; uA0 = urunA; uB0 = urunB;
    for (int b = 0; b < 64; b++) begin
      if (b == 0) lrclk = 1'b1;
      else if (b == 32) lrclk = 1'b0;
      #60;
      bclk = 1'b1;
      bclkRises = b + 1;
      if (b + 1 == chgAt) i_mode = chgMode;
      if (b + 1 == rstAt) begin
        @(posedge i_clock); #1 i_reset = 1'b1;
        @(posedge i_clock); #1 i_reset = 1'b0;
      end
      #60;
      bclk = 1'b0;
    end
  endtask

  initial begin
    i_reset = 1'b1; bclk = 1'b0; lrclk = 1'b0; i_enable = 1'b1; i_mode = 2'd0;
    s0l = '0; s0r = '0; s1l = '0; s1r = '0; s0v = 1'b0; s1v = 1'b0;
    repeat (4) @(posedge i_clock);
    #1 i_reset = 1'b0;
    @(posedge i_clock); #1;
    checkOutput("rst_valid", {31'd0, hValid}, 32'd0);
    checkOutput("rst_data_left", hL, 32'd0);
    checkOutput("rst_frame_count", hFcnt, 32'd0);
    checkOutput("rst_underrun_count", hUcnt, 32'd0);
    checkOutput("rst_src0_ready", {31'd0, hReady0}, 32'd1);

    // Source 0 straight through.
    i_mode = 2'd1;
    offerSrc0(24'h123456, 24'hABCDEF);
    applyStimulus(0, 2'd0, 0);
    checkOutput("m1_issues", validA - vA0, 32'd1);
    checkOutput("m1_left", lastLA, 32'h123456);
    checkOutput("m1_right", lastRA, 32'hABCDEF);
    checkOutput("m1_latency_bclk", bclkAtValid, 32'd28);
    checkOutput("m1_frame_count", hFcnt, 32'd1);
    checkOutput("m1_underrun_count", hUcnt, 32'd0);

    // Saturating sum, both directions.
    i_mode = 2'd3;
    offerSrc0(24'h7FFFF0, 24'h800000);
    offerSrc1(24'h000100, 24'hFFFFFF);
    applyStimulus(0, 2'd0, 0);
    checkOutput("sum_left_pos_sat", lastLA, 32'h7FFFFF);
    checkOutput("sum_right_neg_sat", lastRA, 32'h800000);
    checkOutput("sum_left_nohold", lastLB, 32'h7FFFFF);
    checkOutput("sum_frame_count", hFcnt, 32'd2);

    // Source 1 issues once, then underruns for three frames.
    i_mode = 2'd2;
    offerSrc1(24'h000AAA, 24'h000AAA);
    applyStimulus(0, 2'd0, 0);
    checkOutput("m2_left", lastLA, 32'h000AAA);
    checkOutput("m2_no_underrun", urunA - uA0, 32'd0);
    vA0 = validA; uA0 = urunA; uB0 = urunB;
    for (int f = 0; f < 3; f++) begin
      applyStimulus(0, 2'd0, 0);
      checkOutput("ur_hold_left", lastLA, 32'h000AAA);
      checkOutput("ur_zero_left", lastLB, 32'h000000);
      checkOutput("ur_zero_right", lastRB, 32'h000000);
      checkOutput("ur_pulse_hold", urunA - uA0, 32'd1);
      checkOutput("ur_pulse_zero", urunB - uB0, 32'd1);
    end
    checkOutput("ur_count_hold", hUcnt, 32'd3);
    checkOutput("ur_count_zero", zUcnt, 32'd3);
    checkOutput("ur_frame_count", hFcnt, 32'd6);

    // Mode change mid-frame takes effect from the next frame.
    i_mode = 2'd1;
    offerSrc0(24'h111111, 24'h222222);
    offerSrc1(24'h333333, 24'h444444);
    applyStimulus(10, 2'd2, 0);
    checkOutput("mchg_cur_left", lastLA, 32'h111111);
    checkOutput("mchg_cur_right", lastRA, 32'h222222);
    checkOutput("mchg_src0_ready", {31'd0, hReady0}, 32'd1);
    checkOutput("mchg_src1_ready", {31'd0, hReady1}, 32'd1);
    offerSrc0(24'h555555, 24'h666666);
    offerSrc1(24'h777777, 24'h888888);
    applyStimulus(0, 2'd0, 0);
    checkOutput("mchg_next_left", lastLA, 32'h777777);
    checkOutput("mchg_next_right", lastRA, 32'h888888);
    checkOutput("mchg_src0_drained", {31'd0, hReady0}, 32'd1);
    checkOutput("mchg_frame_count", hFcnt, 32'd8);
    checkOutput("mchg_underrun_count", hUcnt, 32'd3);

    // Disable for two frames: no issues, readies low, buffers flushed.
    offerSrc0(24'h0A0A0A, 24'h0A0A0A);
    offerSrc1(24'h0B0B0B, 24'h0B0B0B);
    @(posedge i_clock); #1 i_enable = 1'b0;
    #1;
    checkOutput("dis_src0_ready", {31'd0, hReady0}, 32'd0);
    checkOutput("dis_src1_ready", {31'd0, hReady1}, 32'd0);
    applyStimulus(0, 2'd0, 0);
    applyStimulus(0, 2'd0, 0);
    checkOutput("dis_no_issue", validA - vA0, 32'd0);
    checkOutput("dis_frame_count", hFcnt, 32'd8);
    @(posedge i_clock); #1 i_enable = 1'b1;
    #1;
    checkOutput("reen_src0_flushed", {31'd0, hReady0}, 32'd1);
    checkOutput("reen_src1_flushed", {31'd0, hReady1}, 32'd1);
    offerSrc1(24'h0ABCDE, 24'h0FEDCB);
    applyStimulus(0, 2'd0, 0);
    checkOutput("reen_issues", validA - vA0, 32'd1);
    checkOutput("reen_left", lastLA, 32'h0ABCDE);
    checkOutput("reen_right", lastRA, 32'h0FEDCB);
    checkOutput("reen_frame_count", hFcnt, 32'd9);

    // Reset in the middle of counting abandons the frame.
    offerSrc1(24'h0C0C0C, 24'h0D0D0D);
    applyStimulus(0, 2'd0, 20);
    checkOutput("midrst_no_issue", validA - vA0, 32'd0);
    checkOutput("midrst_frame_count", hFcnt, 32'd0);
    checkOutput("midrst_underrun_count", hUcnt, 32'd0);
    checkOutput("midrst_zero_frame_count", zFcnt, 32'd0);
    checkOutput("midrst_src1_ready", {31'd0, hReady1}, 32'd1);
    offerSrc1(24'h013579, 24'h02468A);
    applyStimulus(0, 2'd0, 0);
    checkOutput("postrst_issues", validA - vA0, 32'd1);
    checkOutput("postrst_left", lastLA, 32'h013579);
    checkOutput("postrst_right", lastRA, 32'h02468A);
    checkOutput("postrst_latency_bclk", bclkAtValid, 32'd28);
    checkOutput("postrst_frame_count", hFcnt, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
